// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by a shared 16x-baud tick strobe.
// Synchronises rx, validates the start bit at mid-bit, samples data at bit centres, checks the stop bit.
module uart_rx_os16 #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_done,
   output logic            frame_err,
   output logic            busy
);

   localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t          state_q;
   logic            sync1_q;
   logic            rx_s_q;
   logic [3:0]      tick_cnt_q;
   logic [BW-1:0]   bit_cnt_q;
   logic [DBIT-1:0] shreg_q;
   logic [DBIT-1:0] rx_data_q;
   logic            rx_done_q;
   logic            frame_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= rx;
         rx_s_q      <= sync1_q;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  tick_cnt_q <= '0;
                  state_q    <= START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (tick_cnt_q == 4'd7) begin
                     // Line high at mid start bit means a glitch: drop it silently.
                     if (!rx_s_q) begin
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= DATA;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 4'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (tick_cnt_q == 4'd15) begin
                     tick_cnt_q <= '0;
                     shreg_q    <= {rx_s_q, shreg_q[DBIT-1:1]};
                     if (bit_cnt_q == BW'(DBIT - 1)) begin
                        state_q <= STOP;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 4'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (tick_cnt_q == 4'(SB_TICK - 1)) begin
                     if (rx_s_q) begin
                        rx_data_q <= shreg_q;
                        rx_done_q <= 1'b1;
                        state_q   <= IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_IDLE;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 4'd1;
                  end
               end
            end
            WAIT_IDLE: begin
               // A held-low line (break) must not look like a fresh start bit.
               if (rx_s_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule
